// File: rtl/rf_arb_pkg.sv
// Shared sizing constants and round-robin pointer helper for the register-file
// write arbiter.
package rf_arb_pkg;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(NREQ - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// searching upward modulo NREQ; nothing granted while hold is high.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N = NREQ
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    input  logic          hold,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!any && !hold && valid[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = PW'(c);
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters with a
// round-robin grant, registered write strobe/address/data and r0 suppression.
module rf_write_arbiter
    import rf_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 ctrl_writeEnable,
    output logic [AW-1:0]        ctrl_writeReg,
    output logic [DW-1:0]        data_writeReg,
    output logic                 busy
);
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;

    // Reset is folded into hold so no handshake can complete while it is asserted.
    rr_arbiter #(.N(NREQ)) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .hold  (hold | reset),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (gany) begin
            rr_ptr_d = rr_next(gidx);
            waddr_d  = req_addr[int'(gidx)*AW +: AW];
            wdata_d  = req_data[int'(gidx)*DW +: DW];
            we_d     = (req_addr[int'(gidx)*AW +: AW] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign req_ready        = grant;
    assign busy             = |(req_valid & ~grant);
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = waddr_q;
    assign data_writeReg    = wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector bench for rf_write_arbiter: table of single-cycle vectors
// plus hand-written reset, fairness and mid-stream reset sequences.
module tb_rf_write_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 ctrl_writeEnable;
    logic [AW-1:0]        ctrl_writeReg;
    logic [DW-1:0]        data_writeReg;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .hold             (hold),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            hold;
        logic [2:0]      valid;
        logic [14:0]     addr;
        logic [95:0]     data;
        logic [2:0]      exp_ready;
        logic            exp_busy;
        logic            exp_we;
        logic [4:0]      exp_addr;
        logic [31:0]     exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic h, input logic [2:0] v,
                                input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                                input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                                input logic [2:0] rdy, input logic bsy,
                                input logic we, input logic [4:0] ea, input logic [31:0] ed);
        vec_t r;
        r.hold = h; r.valid = v;
        r.addr = {a2, a1, a0};
        r.data = {d2, d1, d0};
        r.exp_ready = rdy; r.exp_busy = bsy;
        r.exp_we = we; r.exp_addr = ea; r.exp_data = ed;
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        req_valid = 3'b111; req_addr = '0; req_data = '0;

        // Reset held 3 cycles with all requesters valid
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_we", 32'(ctrl_writeEnable), 32'h0);
            chk("rst_addr", 32'(ctrl_writeReg), 32'h0);
            chk("rst_data", data_writeReg, 32'h0);
            @(posedge clk);
        end
        #1 reset = 1'b0;

        // Fairness from reset: 0,1,2,0,1,2
        req_addr = {5'd6, 5'd5, 5'd4};
        req_data = {32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 6; i++) begin
            #3;
            chk("fair_ready", 32'(req_ready), 32'(3'b001 << (i % 3)));
            chk("fair_busy", 32'(busy), 32'h1);
            @(posedge clk);
            #1;
            chk("fair_addr", 32'(ctrl_writeReg), 32'(4 + (i % 3)));
        end

        req_valid = '0;
        do_reset();

        vecs[0]  = mk(0, 3'b010, 0, 7, 0, 0, 32'hDEADBEEF, 0, 3'b010, 0, 1, 7, 32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b111, 4, 2, 1, 12, 11, 10, 3'b100, 1, 1, 4, 12);
        vecs[2]  = mk(0, 3'b111, 4, 2, 1, 12, 11, 10, 3'b001, 1, 1, 1, 10);
        vecs[3]  = mk(0, 3'b111, 4, 2, 1, 12, 11, 10, 3'b010, 1, 1, 2, 11);
        vecs[4]  = mk(0, 3'b000, 4, 2, 1, 12, 11, 10, 3'b000, 0, 0, 2, 11);
        vecs[5]  = mk(0, 3'b001, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 1);
        vecs[6]  = mk(1, 3'b101, 9, 0, 8, 22, 0, 21, 3'b000, 1, 0, 0, 1);
        vecs[7]  = mk(1, 3'b101, 9, 0, 8, 22, 0, 21, 3'b000, 1, 0, 0, 1);
        vecs[8]  = mk(0, 3'b101, 9, 0, 8, 22, 0, 21, 3'b100, 1, 1, 9, 22);
        vecs[9]  = mk(0, 3'b101, 3, 0, 3, 32'hB, 0, 32'hA, 3'b001, 1, 1, 3, 32'hA);
        vecs[10] = mk(0, 3'b100, 3, 0, 3, 32'hB, 0, 32'hA, 3'b100, 0, 1, 3, 32'hB);

        foreach (vecs[i]) begin
            hold = vecs[i].hold;
            req_valid = vecs[i].valid;
            req_addr = vecs[i].addr;
            req_data = vecs[i].data;
            #3;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(ctrl_writeEnable), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_addr", i), 32'(ctrl_writeReg), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_data", i), data_writeReg, vecs[i].exp_data);
        end
        hold = 1'b0;

        // Mid-stream async reset discards the pending write
        req_valid = 3'b010;
        req_addr = {5'd0, 5'd17, 5'd0};
        req_data = {32'h0, 32'hCAFEF00D, 32'h0};
        @(posedge clk);
        #1;
        chk("mid_we_before", 32'(ctrl_writeEnable), 32'h1);
        chk("mid_addr_before", 32'(ctrl_writeReg), 32'd17);
        #2 reset = 1'b1;
        #1;
        chk("mid_we", 32'(ctrl_writeEnable), 32'h0);
        chk("mid_addr", 32'(ctrl_writeReg), 32'h0);
        chk("mid_data", data_writeReg, 32'h0);
        chk("mid_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_we_held", 32'(ctrl_writeEnable), 32'h0);
        reset = 1'b0;
        #2;
        chk("post_rst_ready", 32'(req_ready), 32'b010);
        req_valid = '0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (32 × 32-bit `register` array, one write enable per entry) among three writeback requesters: ALU pipeline, multdiv unit, exception/status path. Each cycle it selects at most one valid requester round-robin, drops writes to register 0, and drives a registered write strobe, address and data into the register file's decoder. It sits between the writeback stages and the register file, replacing direct wiring of the write port.

## Interface
Parameters:
- NREQ, 3: number of requesters (fixed at 3 in this design; logic written for NREQ).
- AW, 5: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  freeze; while high no request is granted.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot (or zero) grant; transfer when req_valid[i] & req_ready[i].
- ctrl_writeEnable  out  1  registered write strobe to register file.
- ctrl_writeReg  out  AW  registered write address.
- data_writeReg  out  DW  registered write data.
- busy  out  1  high when any req_valid bit is high and not granted this cycle.

## Operation
- Round-robin pointer `rr_ptr` (0..NREQ-1) names the highest-priority requester; search order rr_ptr, rr_ptr+1, … mod NREQ.
- req_ready is combinational from req_valid, rr_ptr, hold; req_ready[i] never depends on req_ready of any other requester's handshake.
- hold = 1: req_ready = 0, rr_ptr unchanged, ctrl_writeEnable = 0 next cycle.
- On a transfer from requester g: rr_ptr <= (g+1) mod NREQ; output register loads req_addr[g], req_data[g]; ctrl_writeEnable <= (req_addr[g] != 0).
- Write to address 0: handshake completes (req_ready high), output addr/data still load, but ctrl_writeEnable = 0.
- No transfer: ctrl_writeEnable <= 0; ctrl_writeReg/data_writeReg hold previous values.
- Two requesters targeting the same address in one cycle: no merging; the loser retries and overwrites on a later cycle (last-granted wins).
- busy = |req_valid & ~req_ready.
- Requesters may drop req_valid without a grant; arbiter keeps no per-request state.

## Timing
- Reset (async assert, any time): ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, rr_ptr = 0; req_ready = 0 while reset high. Reset mid-grant discards the pending output write.
- Latency: handshake in cycle t → ctrl_writeEnable/addr/data valid during cycle t+1, written into the register file on the edge ending t+1.
- Throughput: one write per cycle; with all NREQ requesters continuously valid each is granted exactly once per NREQ cycles.
- rr_ptr wraps NREQ-1 → 0.
- Release of reset: first grant possible in the first cycle with reset low.

## Structure
- Package `rf_arb_pkg`: NREQ, AW, DW constants; function `rr_next(ptr)` for modular increment.
- Sub-module `rr_arbiter` (NREQ): inputs valid, ptr, hold; outputs one-hot grant and encoded index. Top level holds rr_ptr, output register, address-0 suppression.

## Test plan
- Reset: hold reset 3 cycles with req_valid=3'b111 → req_ready=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0; assert reset mid-stream after a grant → outputs return to 0 immediately, no write issued.
- Single request: req_valid=3'b010, addr1=5'd7, data1=32'hDEADBEEF → req_ready=3'b010 same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=7, data_writeReg=32'hDEADBEEF; rr_ptr=2.
- Fairness: req_valid=3'b111 for 6 cycles from reset → grant order 0,1,2,0,1,2; busy=1 every cycle.
- Register 0: requester 0 valid, addr=0, data=32'h1 → req_ready[0]=1, next cycle ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=1.
- Hold: req_valid=3'b101 with hold=1 for 2 cycles → req_ready=0, ctrl_writeEnable=0, busy=1, rr_ptr unchanged; hold drops → requester at rr_ptr granted first.
- Same-address collision: requesters 0 and 2 both addr=5'd3, data 32'hA and 32'hB, rr_ptr=0 → write 32'hA at t+1, 32'hB at t+2; final ctrl_writeReg=3 with data 32'hB.
